// File: rtl/lsu.sv
// Load/store unit: one outstanding access, lane shifting, load extension.
// Optional MISALIGN_TRAP_EN turns misaligned accesses into a trap pulse.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_rw,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        misalign
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, RESP, DRAIN
  } state_t;

  state_t      state_q;
  logic        mem_valid_q;
  logic        mem_rw_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  mem_wstrb_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [63:0] wb_data_q;
  logic        misalign_q;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        trap;
  logic [2:0]  off_d;
  logic [7:0]  strb_d;
  logic [63:0] wdata_d;
  logic [63:0] rsh;
  logic [63:0] fmt_d;

`ifdef MISALIGN_TRAP_EN
  logic mis;

  // Natural-alignment violation of the incoming request
  always_comb begin
    mis = 1'b0;
    unique case (ex_size)
      2'b01:   mis = ex_addr[0];
      2'b10:   mis = |ex_addr[1:0];
      2'b11:   mis = |ex_addr[2:0];
      default: mis = 1'b0;
    endcase
  end

  assign trap = mis;
`else
  assign trap = 1'b0;
`endif

  // Lane offset (aligned to size), byte strobes and shifted store data
  always_comb begin
    off_d  = ex_addr[2:0];
    strb_d = 8'h01;
    unique case (ex_size)
      2'b00: begin
        off_d  = ex_addr[2:0];
        strb_d = 8'h01;
      end
      2'b01: begin
        off_d  = {ex_addr[2:1], 1'b0};
        strb_d = 8'h03;
      end
      2'b10: begin
        off_d  = {ex_addr[2], 2'b00};
        strb_d = 8'h0F;
      end
      default: begin
        off_d  = 3'b000;
        strb_d = 8'hFF;
      end
    endcase
    strb_d  = strb_d << off_d;
    wdata_d = ex_wdata << {off_d, 3'b000};
  end

  // Shift the returned dword down and extend to the access size
  always_comb begin
    rsh   = mem_rdata >> {off_q, 3'b000};
    fmt_d = rsh;
    unique case (size_q)
      2'b00:
        fmt_d = uns_q ? {56'b0, rsh[7:0]}
                      : {{56{rsh[7]}}, rsh[7:0]};
      2'b01:
        fmt_d = uns_q ? {48'b0, rsh[15:0]}
                      : {{48{rsh[15]}}, rsh[15:0]};
      2'b10:
        fmt_d = uns_q ? {32'b0, rsh[31:0]}
                      : {{32{rsh[31]}}, rsh[31:0]};
      default:
        fmt_d = rsh;
    endcase
  end

  // Transaction FSM with registered mem/wb outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= 64'b0;
      mem_wdata_q <= 64'b0;
      mem_wstrb_q <= 8'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'b0;
      wb_data_q   <= 64'b0;
      misalign_q  <= 1'b0;
      off_q       <= 3'b0;
      size_q      <= 2'b0;
      uns_q       <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      wb_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ex_valid && !flush) begin
            if (trap) begin
              misalign_q <= 1'b1;
            end else begin
              state_q     <= REQ;
              mem_valid_q <= 1'b1;
              mem_rw_q    <= ex_rw;
              mem_addr_q  <= {ex_addr[63:3], 3'b000};
              mem_wdata_q <= ex_rw ? wdata_d : 64'b0;
              mem_wstrb_q <= ex_rw ? strb_d : 8'b0;
              wb_rd_q     <= ex_rd;
              off_q       <= off_d;
              size_q      <= ex_size;
              uns_q       <= ex_unsigned;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (mem_rw_q)   state_q <= IDLE;
            else if (flush) state_q <= DRAIN;
            else            state_q <= WAIT;
          end else if (flush) begin
            mem_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        WAIT: begin
          if (flush) begin
            state_q <= mem_rvalid ? IDLE : DRAIN;
          end else if (mem_rvalid) begin
            wb_data_q  <= fmt_d;
            wb_valid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        DRAIN: begin
          if (mem_rvalid) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ex_ready  = (state_q == IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_valid  = wb_valid_q & ~flush;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;

endmodule
